// File: rtl/regalu_datapath.sv
// Register/ALU datapath responding to the op sequencer strobes, with a strobe-order tracker.
// Optional feature: define REGALU_R0_ZERO_EN to make R0 a hard-wired zero register.
module regalu_datapath #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int PC_W   = 8,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ALU_in1,
    input  logic              ALU_in2,
    input  logic              ALU_tsb_out,
    input  logic              Reg_Dest,
    input  logic              PC_Increment,
    input  logic              Done,
    input  logic [2:0]        op,
    input  logic [AW-1:0]     rs1,
    input  logic [AW-1:0]     rs2,
    input  logic [AW-1:0]     rd,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] alu_bus,
    output logic              alu_bus_vld,
    output logic [PC_W-1:0]   pc,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy,
    output logic              seq_err
);

`ifdef REGALU_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_HAVE_A, S_HAVE_B, S_RESULT} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_result;
    logic                r_carry;
    logic [DATA_W-1:0]   r_pc;
    logic                r_z;
    logic                r_c;
    logic                r_err;

    logic [DATA_W-1:0]   w_aluRes;
    logic                w_aluCarry;
    logic [DATA_W:0]     w_sum;
    logic                w_viol;
    logic                w_destOk;
    logic                w_ldOk;
    logic                w_destWr;

    function automatic logic [DATA_W-1:0] readReg(input logic [AW-1:0] idx);
        return (R0_ZERO && idx == '0) ? '0 : r_regs[idx];
    endfunction

    assign w_viol   = (ALU_in1 && r_state != S_IDLE) || (ALU_in2 && r_state != S_HAVE_A) ||
                      (Reg_Dest && r_state != S_RESULT) || (ALU_tsb_out && r_state != S_RESULT);
    assign w_destOk = Reg_Dest && (r_state == S_RESULT);
    assign w_ldOk   = ld_en && !(R0_ZERO && ld_addr == '0);
    assign w_destWr = w_destOk && !(R0_ZERO && rd == '0);

    always_comb begin
        w_aluRes   = '0;
        w_aluCarry = 1'b0;
        w_sum      = '0;
        case (op)
            3'd0: begin
                w_sum      = {1'b0, r_a} + {1'b0, r_b};
                w_aluRes   = w_sum[DATA_W-1:0];
                w_aluCarry = w_sum[DATA_W];
            end
            3'd1: begin
                w_aluRes   = r_a - r_b;
                w_aluCarry = (r_a < r_b);
            end
            3'd2: w_aluRes = r_a & r_b;
            3'd3: w_aluRes = r_a | r_b;
            3'd4: w_aluRes = r_a ^ r_b;
            3'd5: w_aluRes = ~r_a;
            3'd6: begin
                w_aluRes   = {r_a[DATA_W-2:0], 1'b0};
                w_aluCarry = r_a[DATA_W-1];
            end
            default: w_aluRes = r_b;
        endcase
    end

    // Tracker and operand/result latches; strobes out of order simply do nothing here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (ALU_in1) begin
                    r_a     <= readReg(rs1);
                    r_state <= S_HAVE_A;
                end
                S_HAVE_A: if (ALU_in2) begin
                    r_b     <= readReg(rs2);
                    r_state <= S_HAVE_B;
                end
                S_HAVE_B: begin
                    r_result <= w_aluRes;
                    r_carry  <= w_aluCarry;
                    r_state  <= S_RESULT;
                end
                default: ;
            endcase
            if (Done)
                r_state <= S_IDLE;
        end
    end

    // Reg_Dest is applied after the external load so it wins on an index collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            if (w_ldOk)
                r_regs[ld_addr] <= ld_data;
            if (w_destWr)
                r_regs[rd] <= r_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= '0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (PC_Increment)
                r_pc <= r_pc + 1'b1;
            if (w_destOk) begin
                r_z <= (r_result == '0);
                r_c <= r_carry;
            end
            if (w_viol)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end

    assign alu_bus     = (ALU_tsb_out && r_state == S_RESULT) ? r_result : '0;
    assign alu_bus_vld = ALU_tsb_out;
    assign pc          = r_pc;
    assign flag_z      = r_z;
    assign flag_c      = r_c;
    assign busy        = (r_state != S_IDLE);
    assign seq_err     = r_err;

endmodule

// File: tb/tb_regalu_datapath.sv
// Self-checking bench for regalu_datapath: directed operation scenarios then random strobes,
// compared every cycle against an arithmetic reference model of the register/ALU behaviour.
module tb_regalu_datapath;
    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int PC_W   = 8;
    localparam int AW     = 2;

`ifdef REGALU_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ALU_in1, ALU_in2, ALU_tsb_out, Reg_Dest, PC_Increment, Done;
    logic [2:0]        op;
    logic [AW-1:0]     rs1, rs2, rd, ld_addr;
    logic              ld_en, err_clr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] alu_bus;
    logic              alu_bus_vld;
    logic [PC_W-1:0]   pc;
    logic              flag_z, flag_c, busy, seq_err;

    int checks   = 0;
    int failures = 0;

    typedef enum {M_IDLE, M_HAVE_A, M_HAVE_B, M_RESULT} phase_t;
    phase_t     mPhase;
    logic [7:0] mRegs [NREG];
    logic [7:0] mA, mB, mRes, mPc;
    logic       mCarry, mZ, mC, mErr;

    regalu_datapath #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .ALU_in1(ALU_in1), .ALU_in2(ALU_in2), .ALU_tsb_out(ALU_tsb_out),
        .Reg_Dest(Reg_Dest), .PC_Increment(PC_Increment), .Done(Done),
        .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err_clr(err_clr),
        .alu_bus(alu_bus), .alu_bus_vld(alu_bus_vld), .pc(pc),
        .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU in plain integer arithmetic: returns {carry, result}.
    function automatic logic [8:0] aluModel(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        int r;
        logic c;
        ia = a;
        ib = b;
        c  = 1'b0;
        r  = 0;
        case (o)
            3'd0: begin r = ia + ib; c = (r > 255); end
            3'd1: begin r = ia - ib; c = (ia < ib); end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = 255 - ia;
            3'd6: begin r = ia * 2; c = (ia >= 128); end
            default: r = ib;
        endcase
        return {c, r[7:0]};
    endfunction

    function automatic logic [7:0] modelRead(input logic [AW-1:0] idx);
        return (R0Z && idx == 0) ? 8'h00 : mRegs[idx];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) mRegs[i] = 8'h00;
        mPhase = M_IDLE;
        mA = 0; mB = 0; mRes = 0; mPc = 0;
        mCarry = 0; mZ = 0; mC = 0; mErr = 0;
    endtask

    // Applies one clock edge worth of strobes to the model, using pre-edge register values.
    task automatic modelUpdate();
        logic       viol;
        logic [7:0] rdA, rdB;
        logic [8:0] alu;
        phase_t     ph;
        ph   = mPhase;
        rdA  = modelRead(rs1);
        rdB  = modelRead(rs2);
        viol = (ALU_in1 && ph != M_IDLE) || (ALU_in2 && ph != M_HAVE_A) ||
               (Reg_Dest && ph != M_RESULT) || (ALU_tsb_out && ph != M_RESULT);
        if (PC_Increment) mPc = mPc + 8'd1;
        if (ld_en && !(R0Z && ld_addr == 0)) mRegs[ld_addr] = ld_data;
        if (Reg_Dest && ph == M_RESULT) begin
            if (!(R0Z && rd == 0)) mRegs[rd] = mRes;
            mZ = (mRes == 0);
            mC = mCarry;
        end
        if (ph == M_IDLE && ALU_in1) begin
            mA = rdA; mPhase = M_HAVE_A;
        end else if (ph == M_HAVE_A && ALU_in2) begin
            mB = rdB; mPhase = M_HAVE_B;
        end else if (ph == M_HAVE_B) begin
            alu = aluModel(op, mA, mB);
            mRes = alu[7:0]; mCarry = alu[8]; mPhase = M_RESULT;
        end
        if (Done) mPhase = M_IDLE;
        if (viol) mErr = 1'b1;
        else if (err_clr) mErr = 1'b0;
    endtask

    task automatic clearStrobes();
        ALU_in1 = 0; ALU_in2 = 0; ALU_tsb_out = 0; Reg_Dest = 0;
        PC_Increment = 0; Done = 0; ld_en = 0; err_clr = 0;
    endtask

    // One cycle: check the bus before the edge, step the model at the edge, check state after.
    task automatic applyStimulus();
        #2;
        checkOutput("alu_bus_vld", 32'(alu_bus_vld), 32'(ALU_tsb_out));
        checkOutput("alu_bus", 32'(alu_bus), (ALU_tsb_out && mPhase == M_RESULT) ? 32'(mRes) : 32'h0);
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput("pc", 32'(pc), 32'(mPc));
        checkOutput("flag_z", 32'(flag_z), 32'(mZ));
        checkOutput("flag_c", 32'(flag_c), 32'(mC));
        checkOutput("busy", 32'(busy), 32'(mPhase != M_IDLE));
        checkOutput("seq_err", 32'(seq_err), 32'(mErr));
    endtask

    task automatic loadReg(input logic [AW-1:0] a, input logic [7:0] d);
        clearStrobes();
        ld_en = 1; ld_addr = a; ld_data = d;
        applyStimulus();
        clearStrobes();
    endtask

    task automatic doOp(input logic [2:0] o, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                        input logic [AW-1:0] d, input bit ldCollide);
        clearStrobes(); op = o; rs1 = s1; rs2 = s2; rd = d;
        ALU_in1 = 1; applyStimulus();
        clearStrobes(); ALU_in2 = 1; applyStimulus();
        clearStrobes(); applyStimulus();
        clearStrobes(); ALU_tsb_out = 1; applyStimulus();
        clearStrobes(); ALU_tsb_out = 1; Reg_Dest = 1; PC_Increment = 1;
        if (ldCollide) begin
            ld_en = 1; ld_addr = d; ld_data = 8'hA5;
        end
        applyStimulus();
        clearStrobes(); Done = 1; applyStimulus();
        clearStrobes();
    endtask

    initial begin
        int n;
        clearStrobes();
        op = 0; rs1 = 0; rs2 = 0; rd = 0; ld_addr = 0; ld_data = 0;
        reset = 1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        checkOutput("rst_pc", 32'(pc), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_err", 32'(seq_err), 32'h0);
        checkOutput("rst_flags", 32'({flag_z, flag_c}), 32'h0);

        loadReg(2'd1, 8'h05);
        loadReg(2'd2, 8'h03);
        doOp(3'd0, 2'd1, 2'd2, 2'd3, 1'b0);
        checkOutput("t1_pc", 32'(pc), 32'h1);
        checkOutput("t1_z", 32'(flag_z), 32'h0);
        checkOutput("t1_c", 32'(flag_c), 32'h0);

        loadReg(2'd1, 8'hFF);
        loadReg(2'd2, 8'h01);
        doOp(3'd0, 2'd1, 2'd2, 2'd0, 1'b0);
        checkOutput("t2_z", 32'(flag_z), 32'h1);
        checkOutput("t2_c", 32'(flag_c), 32'h1);
        doOp(3'd7, 2'd1, 2'd0, 2'd3, 1'b0);

        loadReg(2'd1, 8'h02);
        loadReg(2'd2, 8'h05);
        doOp(3'd1, 2'd1, 2'd2, 2'd3, 1'b0);
        checkOutput("t3_sub_c", 32'(flag_c), 32'h1);
        loadReg(2'd1, 8'h81);
        doOp(3'd6, 2'd1, 2'd2, 2'd3, 1'b0);
        checkOutput("t3_shl_c", 32'(flag_c), 32'h1);
        checkOutput("t3_shl_z", 32'(flag_z), 32'h0);

        clearStrobes(); rs2 = 2'd2; ALU_in2 = 1; applyStimulus();
        checkOutput("t4_err_set", 32'(seq_err), 32'h1);
        checkOutput("t4_busy", 32'(busy), 32'h0);
        clearStrobes(); err_clr = 1; applyStimulus();
        checkOutput("t4_err_clr", 32'(seq_err), 32'h0);
        clearStrobes();

        n = 255 - int'(mPc);
        for (int i = 0; i < n; i++) begin
            clearStrobes(); PC_Increment = 1; applyStimulus();
        end
        checkOutput("t5_pc_max", 32'(pc), 32'hFF);
        clearStrobes(); PC_Increment = 1; applyStimulus();
        checkOutput("t5_pc_wrap", 32'(pc), 32'h0);
        doOp(3'd3, 2'd1, 2'd2, 2'd2, 1'b1);
        doOp(3'd7, 2'd1, 2'd2, 2'd1, 1'b0);

        clearStrobes(); op = 3'd0; rs1 = 2'd1; rs2 = 2'd2;
        ALU_in1 = 1; applyStimulus();
        clearStrobes(); ALU_in2 = 1; applyStimulus();
        clearStrobes();
        reset = 1;
        #2;
        modelReset();
        checkOutput("t6_busy", 32'(busy), 32'h0);
        checkOutput("t6_pc", 32'(pc), 32'h0);
        checkOutput("t6_err", 32'(seq_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 0;
        doOp(3'd7, 2'd0, 2'd1, 2'd2, 1'b0);
        loadReg(2'd3, 8'h40);
        doOp(3'd0, 2'd3, 2'd3, 2'd1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            clearStrobes();
            op  = 3'($urandom_range(0, 7));
            rs1 = AW'($urandom_range(0, NREG - 1));
            rs2 = AW'($urandom_range(0, NREG - 1));
            rd  = AW'($urandom_range(0, NREG - 1));
            if ($urandom_range(0, 99) < 8) begin
                Done = 1;
            end else begin
                ALU_in1     = ($urandom_range(0, 99) < 30);
                ALU_in2     = ($urandom_range(0, 99) < 30);
                ALU_tsb_out = ($urandom_range(0, 99) < 30);
                Reg_Dest    = ($urandom_range(0, 99) < 20);
            end
            PC_Increment = Reg_Dest ? 1'b1 : ($urandom_range(0, 9) == 0);
            ld_en   = ($urandom_range(0, 99) < 20);
            ld_addr = AW'($urandom_range(0, NREG - 1));
            ld_data = 8'($urandom_range(0, 255));
            err_clr = ($urandom_range(0, 99) < 15);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
